// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM-stage load/store unit feeding the MEM->WB pipeline register.
//   Non-memory ops pass straight through in the same cycle. An aligned load or
//   store is latched, and then one req/ack transaction runs with data memory.
//   Upstream is stalled until the transaction completes.
//   Misaligned accesses and illegal size codes raise a one-cycle mem_fault and
//   issue no memory request.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   EX_*              operation from the EX/MEM register
//   dmem_req/wr/addr/wdata/be, dmem_ack/rdata
//                     data memory request/acknowledge handshake
//   Mem_data_mem, MEM_rd, MEM_we
//                     result, destination and write enable to MEM->WB
//   mem_stall         hold the EX/MEM stage
//   mem_fault         misaligned or illegal access (one-cycle pulse)
//
// States
//   IDLE | waiting; non-memory ops pass through; memory op is latched on accept
//   BUSY | request outstanding on dmem_*; waiting for dmem_ack
//   DONE | formatted result presented to MEM->WB for one cycle
module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EX_valid,
    input  logic [XLEN-1:0] EX_alu_res,
    input  logic [XLEN-1:0] EX_store_data,
    input  logic [4:0]      EX_rd,
    input  logic            EX_we,
    input  logic            EX_is_load,
    input  logic            EX_is_store,
    input  logic [2:0]      EX_funct3,
    output logic            dmem_req,
    output logic            dmem_wr,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] Mem_data_mem,
    output logic [4:0]      MEM_rd,
    output logic            MEM_we,
    output logic            mem_stall,
    output logic            mem_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;

    logic [XLEN-1:0] op_addr;
    logic [XLEN-1:0] op_data;
    logic [4:0]      op_rd;
    logic            op_we;
    logic [2:0]      op_funct3;
    logic            op_load;
    logic [XLEN-1:0] op_result;

    logic            accept;
    logic            capture;
    logic            is_mem;
    logic            illegal;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_fmt;

    assign is_mem = EX_is_load | EX_is_store;

    // Size is taken from funct3[1:0]; funct3[2] only selects zero-extension.
    always_comb begin
        illegal = 1'b0;
        case (EX_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            default: begin
                if (EX_funct3[1:0] == 2'b01 && EX_alu_res[0])
                    illegal = 1'b1;
                if (EX_funct3[1:0] == 2'b10 && EX_alu_res[1:0] != 2'b00)
                    illegal = 1'b1;
            end
        endcase
    end

    // Memory-side drive comes only from latched registers, so it stays
    // stable for the whole time the request is outstanding.
    assign dmem_wr   = ~op_load;
    assign dmem_addr = {op_addr[XLEN-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = op_data;
        case (op_funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << op_addr[1:0];
                dmem_wdata = {4{op_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << op_addr[1:0];
                dmem_wdata = {2{op_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = op_data;
            end
        endcase
        if (op_load)
            dmem_be = 4'b0000;
    end

    assign lane = dmem_rdata >> {op_addr[1:0], 3'b000};

    always_comb begin
        case (op_funct3)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'd0, lane[7:0]};
            3'b101:  load_fmt = {16'd0, lane[15:0]};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_addr   <= '0;
            op_data   <= '0;
            op_rd     <= '0;
            op_we     <= 1'b0;
            op_funct3 <= '0;
            op_load   <= 1'b0;
            op_result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_addr   <= EX_alu_res;
                op_data   <= EX_store_data;
                op_rd     <= EX_rd;
                op_we     <= EX_we;
                op_funct3 <= EX_funct3;
                op_load   <= EX_is_load;
            end
            if (capture)
                op_result <= load_fmt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        capture      = 1'b0;
        dmem_req     = 1'b0;
        Mem_data_mem = '0;
        MEM_rd       = '0;
        MEM_we       = 1'b0;
        mem_stall    = 1'b0;
        mem_fault    = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (EX_valid) begin
                        if (!is_mem) begin
                            Mem_data_mem = EX_alu_res;
                            MEM_rd       = EX_rd;
                            MEM_we       = EX_we;
                        end else if (illegal) begin
                            mem_fault = 1'b1;
                        end else begin
                            accept    = 1'b1;
                            mem_stall = 1'b1;
                            state_nxt = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                    if (dmem_ack) begin
                        capture   = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    // EX still shows the completed op here; it must not be
                    // accepted a second time.
                    Mem_data_mem = op_result;
                    MEM_rd       = op_rd;
                    MEM_we       = op_we & op_load;
                    state_nxt    = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_valid;
    logic [31:0] EX_alu_res;
    logic [31:0] EX_store_data;
    logic [4:0]  EX_rd;
    logic        EX_we;
    logic        EX_is_load;
    logic        EX_is_store;
    logic [2:0]  EX_funct3;
    logic        dmem_req;
    logic        dmem_wr;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] Mem_data_mem;
    logic [4:0]  MEM_rd;
    logic        MEM_we;
    logic        mem_stall;
    logic        mem_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .EX_valid(EX_valid), .EX_alu_res(EX_alu_res), .EX_store_data(EX_store_data),
        .EX_rd(EX_rd), .EX_we(EX_we), .EX_is_load(EX_is_load), .EX_is_store(EX_is_store),
        .EX_funct3(EX_funct3),
        .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .Mem_data_mem(Mem_data_mem), .MEM_rd(MEM_rd), .MEM_we(MEM_we),
        .mem_stall(mem_stall), .mem_fault(mem_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, legality, lanes and load result
    function automatic int sz_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit legal_op(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        return (int'(addr[1:0]) % sz_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint unsigned v;
        longint unsigned span;
        int sz;
        sz   = sz_of(f3);
        span = 64'd1 << (8 * sz);
        v    = {32'd0, rdata} >> (8 * int'(addr[1:0]));
        v    = v % span;
        if (!f3[2] && sz < 4 && v >= (span >> 1))
            v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input bit ld, input logic [2:0] f3, input logic [31:0] addr);
        int t;
        if (ld) return 4'b0000;
        t = ((1 << sz_of(f3)) - 1) << int'(addr[1:0]);
        return t[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (sz_of(f3) == 1) return d[7:0] * 32'h0101_0101;
        if (sz_of(f3) == 2) return d[15:0] * 32'h0001_0001;
        return d;
    endfunction

    task automatic set_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input logic we);
        EX_valid      = 1'b1;
        EX_is_load    = ld;
        EX_is_store   = st;
        EX_funct3     = f3;
        EX_alu_res    = addr;
        EX_store_data = sdata;
        EX_rd         = rd;
        EX_we         = we;
    endtask

    task automatic clr_op();
        EX_valid    = 1'b0;
        EX_is_load  = 1'b0;
        EX_is_store = 1'b0;
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic do_mem(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input logic we,
                          input int n, input logic [31:0] rdata);
        int stall_cnt;
        int req_cnt;
        stall_cnt = 0;
        req_cnt   = 0;
        set_op(ld, !ld, f3, addr, sdata, rd, we);
        dmem_ack = 1'b0;
        #1;
        chk("accept_req", dmem_req, 1'b0);
        chk("accept_we", MEM_we, 1'b0);
        chk("accept_fault", mem_fault, 1'b0);
        stall_cnt += int'(mem_stall);
        @(negedge clk);
        for (int i = 1; i <= n; i++) begin
            dmem_ack   = (i == n);
            dmem_rdata = (i == n) ? rdata : $urandom;
            #1;
            chk("busy_req", dmem_req, 1'b1);
            chk("busy_wr", dmem_wr, !ld);
            chk("busy_addr", dmem_addr, addr - (addr % 4));
            chk("busy_be", dmem_be, ref_be(ld, f3, addr));
            if (!ld) chk("busy_wdata", dmem_wdata, ref_wdata(f3, sdata));
            chk("busy_we", MEM_we, 1'b0);
            stall_cnt += int'(mem_stall);
            req_cnt   += int'(dmem_req);
            @(negedge clk);
        end
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        #1;
        chk("done_req", dmem_req, 1'b0);
        chk("done_stall", mem_stall, 1'b0);
        chk("done_we", MEM_we, we & ld);
        chk("done_rd", MEM_rd, rd);
        if (ld) chk("done_data", Mem_data_mem, ref_load(f3, addr, rdata));
        chk("stall_cycles", stall_cnt, n + 1);
        chk("req_cycles", req_cnt, n);
        @(negedge clk);
        clr_op();
        #1;
        chk("after_req", dmem_req, 1'b0);
        chk("after_stall", mem_stall, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_bad(input bit ld, input logic [2:0] f3, input logic [31:0] addr);
        set_op(ld, !ld, f3, addr, $urandom, 5'd3, 1'b1);
        #1;
        chk("bad_fault", mem_fault, 1'b1);
        chk("bad_req", dmem_req, 1'b0);
        chk("bad_stall", mem_stall, 1'b0);
        chk("bad_we", MEM_we, 1'b0);
        @(negedge clk);
        clr_op();
        #1;
        chk("bad_fault_clr", mem_fault, 1'b0);
        chk("bad_req_next", dmem_req, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        set_op(1'b0, 1'b0, 3'd0, 32'h55, 32'd0, 5'd5, 1'b1);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        chk("rst_we", MEM_we, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_fault", mem_fault, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1;
        clr_op();
        #1;
        chk("idle_ack_req", dmem_req, 1'b0);
        chk("idle_we", MEM_we, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("idle_ack_ignored", dmem_req, 1'b0);
        @(negedge clk);

        // LW 0x104, ack on 3rd BUSY cycle
        do_mem(1'b1, 3'b010, 32'h104, 32'd0, 5'd7, 1'b1, 3, 32'hDEADBEEF);
        // load formatting
        do_mem(1'b1, 3'b000, 32'h103, 32'd0, 5'd8, 1'b1, 1, 32'h80123456);
        do_mem(1'b1, 3'b100, 32'h103, 32'd0, 5'd8, 1'b1, 2, 32'h80123456);
        do_mem(1'b1, 3'b001, 32'h102, 32'd0, 5'd9, 1'b1, 1, 32'h80123456);
        do_mem(1'b1, 3'b101, 32'h100, 32'd0, 5'd9, 1'b1, 1, 32'h80123456);
        // stores
        do_mem(1'b0, 3'b000, 32'h101, 32'h0000_00AB, 5'd1, 1'b1, 2, 32'd0);
        do_mem(1'b0, 3'b001, 32'h102, 32'h0000_1234, 5'd1, 1'b1, 1, 32'd0);
        do_mem(1'b0, 3'b010, 32'h200, 32'hCAFE_F00D, 5'd1, 1'b0, 1, 32'd0);
        // faults
        do_bad(1'b1, 3'b010, 32'h102);
        do_bad(1'b0, 3'b001, 32'h101);
        do_bad(1'b1, 3'b011, 32'h100);

        // pass-through then back-to-back load
        set_op(1'b0, 1'b0, 3'd0, 32'h55, 32'hFFFF_FFFF, 5'd5, 1'b1);
        #1;
        chk("pt_data", Mem_data_mem, 32'h55);
        chk("pt_rd", MEM_rd, 5'd5);
        chk("pt_we", MEM_we, 1'b1);
        chk("pt_stall", mem_stall, 1'b0);
        chk("pt_req", dmem_req, 1'b0);
        @(negedge clk);
        do_mem(1'b1, 3'b010, 32'h300, 32'd0, 5'd6, 1'b1, 1, 32'h1357_9BDF);

        // reset during BUSY, late ack
        set_op(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 5'd4, 1'b1);
        @(negedge clk);
        #1;
        chk("rb_busy_req", dmem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        clr_op();
        #1;
        chk("rb_rst_req", dmem_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rb_idle_req", dmem_req, 1'b0);
        chk("rb_idle_stall", mem_stall, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rb_ack_req", dmem_req, 1'b0);
        chk("rb_ack_we", MEM_we, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("rb_after_we", MEM_we, 1'b0);
        chk("rb_after_stall", mem_stall, 1'b0);
        chk("rb_after_req", dmem_req, 1'b0);
        @(negedge clk);

        // randomized mix against the reference model
        for (int k = 0; k < 60; k++) begin
            int kind;
            logic [2:0]  f3;
            logic [31:0] addr;
            kind = int'($urandom_range(0, 2));
            addr = $urandom;
            if (kind == 0) begin
                logic [31:0] res;
                logic [4:0]  rd;
                logic        we;
                res = $urandom;
                rd  = 5'($urandom);
                we  = 1'($urandom);
                set_op(1'b0, 1'b0, 3'($urandom), res, $urandom, rd, we);
                #1;
                chk("rnd_pt_data", Mem_data_mem, res);
                chk("rnd_pt_rd", MEM_rd, rd);
                chk("rnd_pt_we", MEM_we, we);
                chk("rnd_pt_stall", mem_stall, 1'b0);
                @(negedge clk);
                clr_op();
            end else begin
                bit ld;
                ld = (kind == 1);
                f3 = f3_tab[$urandom_range(0, 7)];
                if (!ld && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
                if ($urandom_range(0, 1) == 1) addr = addr - (addr % sz_of(f3));
                if (legal_op(f3, addr))
                    do_mem(ld, f3, addr, $urandom, 5'($urandom), 1'($urandom),
                           int'($urandom_range(1, 4)), $urandom);
                else
                    do_bad(ld, f3, addr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
